// File: rtl/pc_pkg.sv
// Shared fetch-path definitions: pc_sel encoding, default vectors and fetch FSM states.
// Imported by the PC unit, the instruction decoder and the hazard unit.
package pc_pkg;

   localparam logic [2:0] PC_SEQ = 3'd0;
   localparam logic [2:0] PC_BR  = 3'd1;
   localparam logic [2:0] PC_J   = 3'd2;
   localparam logic [2:0] PC_JR  = 3'd3;
   localparam logic [2:0] PC_EXC = 3'd4;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } fetch_state_e;

   // Encodings 5..7 fall back to sequential fetch and never redirect.
   function automatic logic is_redirect_sel(input logic [2:0] sel);
      logic res;
      case (sel)
         PC_BR, PC_J, PC_JR, PC_EXC: res = 1'b1;
         default:                    res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/npc_target_calc.sv
// Combinational redirect target selection and JAL/JALR link address.
// All arithmetic wraps modulo 2^ADDR_W.
module npc_target_calc
   import pc_pkg::*;
#(
   parameter int                ADDR_W = 32,
   parameter logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_PC_DEF)
) (
   input  logic [2:0]        pc_sel,
   input  logic [ADDR_W-1:0] base_pc,
   input  logic [15:0]       br_imm,
   input  logic [25:0]       j_idx,
   input  logic [ADDR_W-1:0] jr_target,
   output logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] link_addr
);

   logic [ADDR_W-1:0] seq_s;
   logic [ADDR_W-1:0] br_off_s;
   logic [ADDR_W-1:0] br_target_s;
   logic [ADDR_W-1:0] j_target_s;

   assign seq_s       = base_pc + ADDR_W'(32'd4);
   assign br_off_s    = {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
   assign br_target_s = seq_s + br_off_s;
   assign j_target_s  = {seq_s[ADDR_W-1:28], j_idx, 2'b00};
   assign link_addr   = base_pc + ADDR_W'(32'd8);

   // Target mux; unused encodings resolve to the sequential successor.
   always_comb begin
      target = seq_s;
      case (pc_sel)
         PC_BR:   target = br_target_s;
         PC_J:    target = j_target_s;
         PC_JR:   target = jr_target;
         PC_EXC:  target = EXC_PC;
         default: target = seq_s;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage program counter with stall hold, prioritised redirects and a
// single-entry redirect buffer for requests that arrive while stalled.
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
   parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_PC_DEF)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [2:0]        pc_sel,
   input  logic [ADDR_W-1:0] base_pc,
   input  logic [15:0]       br_imm,
   input  logic [25:0]       j_idx,
   input  logic [ADDR_W-1:0] jr_target,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [ADDR_W-1:0] link_addr,
   output logic              adel,
   output logic              redirect_pending
);

   fetch_state_e      state_r;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pend_target_r;
   logic              pend_exc_r;

   logic [ADDR_W-1:0] target_s;
   logic              redir_s;
   logic              exc_req_s;
   logic              keep_pend_s;

   npc_target_calc #(
      .ADDR_W (ADDR_W),
      .EXC_PC (EXC_PC)
   ) u_npc_target_calc (
      .pc_sel    (pc_sel),
      .base_pc   (base_pc),
      .br_imm    (br_imm),
      .j_idx     (j_idx),
      .jr_target (jr_target),
      .target    (target_s),
      .link_addr (link_addr)
   );

   assign redir_s     = redirect_valid & is_redirect_sel(pc_sel);
   assign exc_req_s   = (pc_sel == PC_EXC);
   // A buffered exception outranks any later non-exception redirect.
   assign keep_pend_s = pend_exc_r & ~exc_req_s;

   // PC register, redirect buffer and IDLE/HELD state in one place.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_r          <= RESET_PC;
         pend_target_r <= '0;
         pend_exc_r    <= 1'b0;
         state_r       <= ST_IDLE;
      end else if (stall && redir_s) begin
         pc_r    <= pc_r;
         state_r <= ST_HELD;
         if (!keep_pend_s) begin
            pend_target_r <= target_s;
            pend_exc_r    <= exc_req_s;
         end else begin
            pend_target_r <= pend_target_r;
            pend_exc_r    <= pend_exc_r;
         end
      end else if (stall) begin
         pc_r          <= pc_r;
         pend_target_r <= pend_target_r;
         pend_exc_r    <= pend_exc_r;
         state_r       <= state_r;
      end else if (redir_s) begin
         pc_r          <= keep_pend_s ? pend_target_r : target_s;
         pend_target_r <= '0;
         pend_exc_r    <= 1'b0;
         state_r       <= ST_IDLE;
      end else if (state_r == ST_HELD) begin
         pc_r          <= pend_target_r;
         pend_target_r <= '0;
         pend_exc_r    <= 1'b0;
         state_r       <= ST_IDLE;
      end else begin
         pc_r          <= pc_r + ADDR_W'(32'd4);
         pend_target_r <= pend_target_r;
         pend_exc_r    <= pend_exc_r;
         state_r       <= state_r;
      end
   end

   assign pc_out           = pc_r;
   assign pc_plus4         = pc_r + ADDR_W'(32'd4);
   assign adel             = (pc_r[1:0] != 2'b00);
   assign redirect_pending = (state_r == ST_HELD);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Table-driven bench for pc_fetch_unit with a queue scoreboard of expected
// post-edge state, plus hand-written link address checks.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        redirect_valid;
   logic [2:0]  pc_sel;
   logic [31:0] base_pc;
   logic [15:0] br_imm;
   logic [25:0] j_idx;
   logic [31:0] jr_target;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic [31:0] link_addr;
   logic        adel;
   logic        redirect_pending;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst_n;
      logic        stl;
      logic        rv;
      logic [2:0]  sel;
      logic [31:0] base;
      logic [15:0] imm;
      logic [25:0] jidx;
      logic [31:0] jr;
      logic [31:0] exp_pc;
      logic        exp_pend;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] pc;
      logic        pend;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   pc_fetch_unit dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .stall            (stall),
      .redirect_valid   (redirect_valid),
      .pc_sel           (pc_sel),
      .base_pc          (base_pc),
      .br_imm           (br_imm),
      .j_idx            (j_idx),
      .jr_target        (jr_target),
      .pc_out           (pc_out),
      .pc_plus4         (pc_plus4),
      .link_addr        (link_addr),
      .adel             (adel),
      .redirect_pending (redirect_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, req);
      end
   endtask

   task automatic add(input logic r, input logic s, input logic rv, input logic [2:0] sel,
                      input logic [31:0] base, input logic [15:0] imm, input logic [25:0] jidx,
                      input logic [31:0] jr, input logic [31:0] epc, input logic epend);
      vec_t v;
      v.rst_n = r; v.stl = s; v.rv = rv; v.sel = sel; v.base = base; v.imm = imm;
      v.jidx = jidx; v.jr = jr; v.exp_pc = epc; v.exp_pend = epend;
      vecs.push_back(v);
   endtask

   initial begin
      exp_t e;
      logic [31:0] exp_p4;
      reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; pc_sel = 3'd0;
      base_pc = 32'd0; br_imm = 16'd0; j_idx = 26'd0; jr_target = 32'd0;

      //  rst  stl  rv   sel   base          imm        jidx          jr            exp_pc        pend
      add(1'b0,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3000,1'b0);
      add(1'b0,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3000,1'b0);
      add(1'b1,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3004,1'b0);
      add(1'b1,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3008,1'b0);
      add(1'b1,1'b0,1'b1,3'd1,32'h0000_3010,16'hFFFC, 26'h0,        32'h0,        32'h0000_3004,1'b0);
      add(1'b1,1'b1,1'b1,3'd2,32'h0000_3020,16'h0,    26'h0000C40,  32'h0,        32'h0000_3004,1'b1);
      add(1'b1,1'b1,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3004,1'b1);
      add(1'b1,1'b1,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3004,1'b1);
      add(1'b1,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3100,1'b0);
      add(1'b1,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3104,1'b0);
      add(1'b1,1'b1,1'b1,3'd4,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3104,1'b1);
      add(1'b1,1'b1,1'b1,3'd3,32'h0,        16'h0,    26'h0,        32'h0000_5000,32'h0000_3104,1'b1);
      add(1'b1,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_4180,1'b0);
      add(1'b1,1'b0,1'b1,3'd3,32'h0,        16'h0,    26'h0,        32'h0000_3002,32'h0000_3002,1'b0);
      add(1'b1,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3006,1'b0);
      add(1'b1,1'b1,1'b1,3'd1,32'h0000_3010,16'h0004, 26'h0,        32'h0,        32'h0000_3006,1'b1);
      add(1'b0,1'b1,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3000,1'b0);
      add(1'b1,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3004,1'b0);
      add(1'b1,1'b1,1'b1,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3004,1'b0);
      add(1'b1,1'b0,1'b1,3'd6,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_3008,1'b0);
      add(1'b1,1'b0,1'b0,3'd1,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_300C,1'b0);
      add(1'b1,1'b1,1'b1,3'd3,32'h0,        16'h0,    26'h0,        32'h0000_7000,32'h0000_300C,1'b1);
      add(1'b1,1'b1,1'b1,3'd3,32'h0,        16'h0,    26'h0,        32'h0000_8000,32'h0000_300C,1'b1);
      add(1'b1,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_8000,1'b0);
      add(1'b1,1'b1,1'b1,3'd4,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_8000,1'b1);
      add(1'b1,1'b0,1'b1,3'd3,32'h0,        16'h0,    26'h0,        32'h0000_9000,32'h0000_4180,1'b0);
      add(1'b1,1'b0,1'b1,3'd3,32'h0,        16'h0,    26'h0,        32'hFFFF_FFFC,32'hFFFF_FFFC,1'b0);
      add(1'b1,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_0000,1'b0);
      add(1'b1,1'b1,1'b1,3'd3,32'h0,        16'h0,    26'h0,        32'h0000_A000,32'h0000_0000,1'b1);
      add(1'b1,1'b0,1'b1,3'd3,32'h0,        16'h0,    26'h0,        32'h0000_B000,32'h0000_B000,1'b0);
      add(1'b1,1'b0,1'b1,3'd3,32'h0,        16'h0,    26'h0,        32'h0000_C000,32'h0000_C000,1'b0);
      add(1'b1,1'b0,1'b1,3'd2,32'h0,        16'h0,    26'h0000001,  32'h0,        32'h0000_0004,1'b0);
      add(1'b1,1'b0,1'b0,3'd0,32'h0,        16'h0,    26'h0,        32'h0,        32'h0000_0008,1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         reset_n        = vecs[i].rst_n;
         stall          = vecs[i].stl;
         redirect_valid = vecs[i].rv;
         pc_sel         = vecs[i].sel;
         base_pc        = vecs[i].base;
         br_imm         = vecs[i].imm;
         j_idx          = vecs[i].jidx;
         jr_target      = vecs[i].jr;
         e.idx = i; e.pc = vecs[i].exp_pc; e.pend = vecs[i].exp_pend;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            check("scoreboard_empty", i, 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            exp_p4 = e.pc + 32'd4;
            check("pc_out", e.idx, pc_out, e.pc);
            check("pc_plus4", e.idx, pc_plus4, exp_p4);
            check("adel", e.idx, {31'd0, adel}, {31'd0, (e.pc[1:0] != 2'b00)});
            check("redirect_pending", e.idx, {31'd0, redirect_pending}, {31'd0, e.pend});
         end
      end

      // link_addr is purely combinational from base_pc
      base_pc = 32'h0000_3010; #1;
      check("link_addr", 0, link_addr, 32'h0000_3018);
      base_pc = 32'hFFFF_FFFC; #1;
      check("link_addr", 1, link_addr, 32'h0000_0004);
      base_pc = 32'h1234_5678; #1;
      check("link_addr", 2, link_addr, 32'h1234_5680);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
